// File: rtl/solicitudes_ascensor.sv
// solicitudes_ascensor: latches cabin/hall calls and picks the next floor to serve for the elevator FSM.
// Scan keeps the travel direction while any qualifying call remains ahead; the door dwell clears a floor.
module solicitudes_ascensor #(
    parameter int DWELL = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_cabina,
    input  logic [2:0] btn_subir,
    input  logic [2:0] btn_bajar,
    input  logic [1:0] piso,
    output logic [3:0] memoria,
    output logic [9:0] pendientes,
    output logic [1:0] direccion,
    output logic       puerta_activa
);
    typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTA} state_t;
    localparam logic [7:0] DW = 8'(DWELL);

    function automatic logic [1:0] lo(input logic [3:0] v);
        return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [1:0] hi(input logic [3:0] v);
        return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [3:0] code_of(input logic [1:0] t, input logic pref_dn,
                                           input logic [3:0] cab, input logic [3:0] up, input logic [3:0] dn);
        logic [3:0] u, d;
        u = 4'd5 + {1'b0, t, 1'b0};
        d = 4'd4 + {1'b0, t, 1'b0};
        return cab[t] ? {2'b0, t} + 4'd1 : (pref_dn ? dn[t] : !up[t]) ? d : u;
    endfunction

    state_t     r_state, r_ret, w_nstate, w_nret, w_dst;
    logic [9:0] r_pend, w_req, w_npend, w_cmask;
    logic [3:0] r_mem, w_nmem;
    logic [7:0] r_cnt, w_ncnt;
    logic [1:0] r_floor, w_nfloor;
    logic       w_clr;
    logic [3:0] w_cab, w_up, w_dn, w_any, w_ge, w_gt;
    logic [3:0] w_upq, w_ab, w_dnq, w_be, w_fm;
    logic [1:0] w_ut, w_dt;
    logic       w_uok, w_dok, w_here;
    logic [3:0] w_ucode, w_dcode, w_hcode;

    // Pending vector bit k-1 holds request code k; presses this cycle take part in the decision.
    assign w_req   = r_pend | {btn_bajar[2], btn_subir[2], btn_bajar[1], btn_subir[1],
                               btn_bajar[0], btn_subir[0], btn_cabina};
    assign w_cab   = w_req[3:0];
    assign w_up    = {1'b0, w_req[8], w_req[6], w_req[4]};
    assign w_dn    = {w_req[9], w_req[7], w_req[5], 1'b0};
    assign w_any   = w_cab | w_up | w_dn;
    assign w_ge    = 4'b1111 << piso;
    assign w_gt    = 4'b1110 << piso;
    assign w_upq   = (w_cab | w_up) & w_ge;
    assign w_ab    = w_any & w_gt;
    assign w_dnq   = (w_cab | w_dn) & ~w_gt;
    assign w_be    = w_any & ~w_ge;
    assign w_uok   = |w_upq | |w_ab;
    assign w_dok   = |w_dnq | |w_be;
    assign w_ut    = |w_upq ? lo(w_upq) : hi(w_ab);
    assign w_dt    = |w_dnq ? hi(w_dnq) : lo(w_be);
    assign w_here  = w_any[piso];
    assign w_ucode = code_of(w_ut, 1'b0, w_cab, w_up, w_dn);
    assign w_dcode = code_of(w_dt, 1'b1, w_cab, w_up, w_dn);
    assign w_hcode = code_of(piso, 1'b0, w_cab, w_up, w_dn);
    assign w_fm    = 4'b0001 << r_floor;
    assign w_cmask = {w_fm[3], w_fm[2], w_fm[2], w_fm[1], w_fm[1], w_fm[0], w_fm};
    assign w_npend = w_req & ~(w_clr ? w_cmask : 10'd0);

    always_comb begin
        w_nstate = r_state;
        w_nret   = r_ret;
        w_nmem   = r_mem;
        w_ncnt   = r_cnt;
        w_nfloor = r_floor;
        w_clr    = 1'b0;
        case (r_state)
            REPOSO: begin
                if (w_here) begin
                    w_nstate = PUERTA;
                    w_nret   = REPOSO;
                    w_nmem   = w_hcode;
                    w_ncnt   = DW;
                    w_nfloor = piso;
                end else if (w_uok) begin
                    w_nstate = SUBIENDO;
                    w_nmem   = w_ucode;
                end else if (w_dok) begin
                    w_nstate = BAJANDO;
                    w_nmem   = w_dcode;
                end else w_nmem = 4'd0;
            end
            SUBIENDO: begin
                if (w_uok) begin
                    w_nmem = w_ucode;
                    if (w_ut == piso) begin
                        w_nstate = PUERTA;
                        w_nret   = SUBIENDO;
                        w_ncnt   = DW;
                        w_nfloor = piso;
                    end
                end else if (|w_be) begin
                    w_nstate = BAJANDO;
                    w_nmem   = w_dcode;
                end else begin
                    w_nstate = REPOSO;
                    w_nmem   = 4'd0;
                end
            end
            BAJANDO: begin
                if (w_dok) begin
                    w_nmem = w_dcode;
                    if (w_dt == piso) begin
                        w_nstate = PUERTA;
                        w_nret   = BAJANDO;
                        w_ncnt   = DW;
                        w_nfloor = piso;
                    end
                end else if (|w_ab) begin
                    w_nstate = SUBIENDO;
                    w_nmem   = w_ucode;
                end else begin
                    w_nstate = REPOSO;
                    w_nmem   = 4'd0;
                end
            end
            PUERTA: begin
                w_ncnt = r_cnt - 8'd1;
                if (r_cnt <= 8'd1) begin
                    w_clr    = 1'b1;
                    w_nstate = r_ret;
                    w_nmem   = 4'd0;
                    w_ncnt   = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REPOSO;
            r_ret   <= REPOSO;
            r_pend  <= '0;
            r_mem   <= '0;
            r_cnt   <= '0;
            r_floor <= '0;
        end else begin
            r_state <= w_nstate;
            r_ret   <= w_nret;
            r_pend  <= w_npend;
            r_mem   <= w_nmem;
            r_cnt   <= w_ncnt;
            r_floor <= w_nfloor;
        end
    end

    // While the door is open the lamp shows the direction we arrived travelling in.
    assign w_dst         = (r_state == PUERTA) ? r_ret : r_state;
    assign direccion     = (w_dst == SUBIENDO) ? 2'd1 : (w_dst == BAJANDO) ? 2'd2 : 2'd0;
    assign puerta_activa = (r_state == PUERTA);
    assign memoria       = r_mem;
    assign pendientes    = r_pend;
endmodule
